// File: rtl/glitc_settings_pkg.sv
// -----------------------------------------------------------------------------
// glitc_settings_pkg
// Shared definitions for the GLITC settings loader: settings register bank
// addresses, status register bit positions, error codes, the loader state
// encoding and the write-sequence address map.
// -----------------------------------------------------------------------------
package glitc_settings_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_UNPAUSE,
    ST_WAIT,
    ST_POLL,
    ST_DONE,
    ST_ERROR
  } state_t;

  // Settings register bank addresses
  localparam logic [3:0] ADDR_VPED_A = 4'h0;
  localparam logic [3:0] ADDR_VPED_B = 4'h1;
  localparam logic [3:0] ADDR_VPED_C = 4'h2;
  localparam logic [3:0] ADDR_VPED_D = 4'h4;
  localparam logic [3:0] ADDR_VPED_E = 4'h5;
  localparam logic [3:0] ADDR_VPED_F = 4'h6;
  localparam logic [3:0] ADDR_ATT_A  = 4'h8;
  localparam logic [3:0] ADDR_ATT_B  = 4'h9;
  localparam logic [3:0] ADDR_ATT_C  = 4'hA;
  localparam logic [3:0] ADDR_ATT_D  = 4'hB;
  localparam logic [3:0] ADDR_ATT_E  = 4'hC;
  localparam logic [3:0] ADDR_ATT_F  = 4'hD;
  localparam logic [3:0] ADDR_STATUS = 4'hE;

  localparam int NUM_WRITES = 12;

  // Status register bit positions
  localparam int STAT_ERR_BIT   = 8;
  localparam int STAT_DONE_BIT  = 16;
  localparam int STAT_PAUSE_BIT = 30;
  localparam int STAT_BUSY_BIT  = 31;

  // Bit of a Vped write word that requests an EEPROM update
  localparam int EEPROM_BIT = 15;

  // Error codes
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_DEVICE  = 2'd2;

  // Address of the idx-th write of the load sequence (Vped A-F, then atten A-F)
  function automatic logic [3:0] write_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    return ADDR_VPED_A;
      4'd1:    return ADDR_VPED_B;
      4'd2:    return ADDR_VPED_C;
      4'd3:    return ADDR_VPED_D;
      4'd4:    return ADDR_VPED_E;
      4'd5:    return ADDR_VPED_F;
      4'd6:    return ADDR_ATT_A;
      4'd7:    return ADDR_ATT_B;
      4'd8:    return ADDR_ATT_C;
      4'd9:    return ADDR_ATT_D;
      4'd10:   return ADDR_ATT_E;
      default: return ADDR_ATT_F;
    endcase
  endfunction

endpackage

// File: rtl/glitc_poll_timer.sv
// -----------------------------------------------------------------------------
// glitc_poll_timer
// Interval and poll-count bookkeeping for the settings loader.
//   clk, rst_n     : clock, asynchronous active-low reset
//   wait_en        : high while the loader sits in its wait state
//   poll_clr       : clears the poll count (new load accepted)
//   poll_inc       : one unsuccessful poll completed
//   interval_done  : last cycle of a POLL_INTERVAL-cycle wait
//   last_poll      : the current poll is number POLL_LIMIT
// -----------------------------------------------------------------------------
module glitc_poll_timer #(
  parameter logic [15:0] POLL_INTERVAL = 16'd1000,
  parameter logic [15:0] POLL_LIMIT    = 16'd500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_en,
  input  logic poll_clr,
  input  logic poll_inc,
  output logic interval_done,
  output logic last_poll
);

  logic [15:0] interval_cnt;
  logic [15:0] poll_cnt;

  // The interval counter restarts from zero every time the wait state is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      interval_cnt <= '0;
      poll_cnt     <= '0;
    end else begin
      interval_cnt <= wait_en ? interval_cnt + 16'd1 : 16'd0;
      if (poll_clr)
        poll_cnt <= '0;
      else if (poll_inc)
        poll_cnt <= poll_cnt + 16'd1;
    end
  end

  assign interval_done = wait_en && (interval_cnt == POLL_INTERVAL - 16'd1);
  assign last_poll     = (poll_cnt == POLL_LIMIT - 16'd1);

endmodule

// File: rtl/glitc_settings_loader.sv
// -----------------------------------------------------------------------------
// glitc_settings_loader
// Loads six pedestal (Vped) and six attenuator settings into the GLITC
// settings register bank, clears the pause bit, then polls the status
// register until the device reports completion, an error, or the poll
// limit is reached.
//   user_clk_i, user_rst_n_i : clock, asynchronous active-low reset
//   start_i                  : one-cycle load request (ignored while busy)
//   vped_i, atten_i, eeprom_i: settings to load (channel A in the low bits)
//   user_sel_o/wr_o/rd_o     : register bank select and strobes
//   user_addr_o, user_dat_o  : register address and write data
//   user_dat_i               : combinational read data
//   busy_o, done_o, err_o    : load status
//   err_code_o, err_msg_o    : error cause and captured status byte
// -----------------------------------------------------------------------------
module glitc_settings_loader
  import glitc_settings_pkg::*;
#(
  parameter logic [15:0] POLL_INTERVAL = 16'd1000,
  parameter logic [15:0] POLL_LIMIT    = 16'd500
) (
  input  logic        user_clk_i,
  input  logic        user_rst_n_i,
  input  logic        start_i,
  input  logic [71:0] vped_i,
  input  logic [35:0] atten_i,
  input  logic        eeprom_i,
  output logic        user_sel_o,
  output logic        user_wr_o,
  output logic        user_rd_o,
  output logic [3:0]  user_addr_o,
  output logic [31:0] user_dat_o,
  input  logic [31:0] user_dat_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic [7:0]  err_msg_o
);

  state_t      state;
  logic [3:0]  idx;
  logic [71:0] vped_q;
  logic [35:0] atten_q;
  logic        eeprom_q;

  logic start_ok;
  logic poll_err;
  logic poll_ok;
  logic poll_inc;
  logic interval_done;
  logic last_poll;
  logic unused_dat;

  function automatic logic [31:0] write_word(input logic [3:0]  widx,
                                             input logic [71:0] vped,
                                             input logic [35:0] atten,
                                             input logic        eeprom);
    logic [31:0] w;
    int          ch;
    w  = '0;
    ch = int'(widx);
    if (ch < 6) begin
      w[11:0]       = vped[ch*12 +: 12];
      w[EEPROM_BIT] = eeprom;
    end else begin
      w[5:0] = atten[(ch-6)*6 +: 6];
    end
    return w;
  endfunction

  always_comb begin
    start_ok = start_i && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
    poll_err = user_dat_i[STAT_ERR_BIT];
    poll_ok  = user_dat_i[STAT_DONE_BIT] && !user_dat_i[STAT_BUSY_BIT];
    poll_inc = (state == ST_POLL) && !poll_err && !poll_ok && !last_poll;
  end

  assign unused_dat = ^{user_dat_i[30:17], user_dat_i[15:9]};

  glitc_poll_timer #(
    .POLL_INTERVAL (POLL_INTERVAL),
    .POLL_LIMIT    (POLL_LIMIT)
  ) u_timer (
    .clk           (user_clk_i),
    .rst_n         (user_rst_n_i),
    .wait_en       (state == ST_WAIT),
    .poll_clr      (start_ok),
    .poll_inc      (poll_inc),
    .interval_done (interval_done),
    .last_poll     (last_poll)
  );

  // Bus outputs are registered for the state being entered, so each strobe is
  // high exactly during the cycle the FSM spends in WRITE/UNPAUSE/POLL. The
  // first write word is built from the live inputs since capture happens on
  // the same edge.
  always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
    if (!user_rst_n_i) begin
      state       <= ST_IDLE;
      idx         <= '0;
      vped_q      <= '0;
      atten_q     <= '0;
      eeprom_q    <= 1'b0;
      user_sel_o  <= 1'b0;
      user_wr_o   <= 1'b0;
      user_rd_o   <= 1'b0;
      user_addr_o <= '0;
      user_dat_o  <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      err_code_o  <= ERR_NONE;
      err_msg_o   <= '0;
    end else begin
      user_sel_o  <= 1'b0;
      user_wr_o   <= 1'b0;
      user_rd_o   <= 1'b0;
      user_addr_o <= '0;
      user_dat_o  <= '0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start_i) begin
            vped_q      <= vped_i;
            atten_q     <= atten_i;
            eeprom_q    <= eeprom_i;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            err_code_o  <= ERR_NONE;
            err_msg_o   <= '0;
            busy_o      <= 1'b1;
            idx         <= '0;
            state       <= ST_WRITE;
            user_sel_o  <= 1'b1;
            user_wr_o   <= 1'b1;
            user_addr_o <= write_addr(4'd0);
            user_dat_o  <= write_word(4'd0, vped_i, atten_i, eeprom_i);
          end
        end
        ST_WRITE: begin
          user_sel_o <= 1'b1;
          user_wr_o  <= 1'b1;
          if (idx == 4'(NUM_WRITES - 1)) begin
            state       <= ST_UNPAUSE;
            user_addr_o <= ADDR_STATUS;
            user_dat_o  <= 32'h0000_0000;
          end else begin
            idx         <= idx + 4'd1;
            user_addr_o <= write_addr(idx + 4'd1);
            user_dat_o  <= write_word(idx + 4'd1, vped_q, atten_q, eeprom_q);
          end
        end
        ST_UNPAUSE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (interval_done) begin
            state       <= ST_POLL;
            user_sel_o  <= 1'b1;
            user_rd_o   <= 1'b1;
            user_addr_o <= ADDR_STATUS;
          end
        end
        ST_POLL: begin
          // A device error outranks a simultaneous completion flag.
          if (poll_err) begin
            state      <= ST_ERROR;
            busy_o     <= 1'b0;
            err_o      <= 1'b1;
            err_code_o <= ERR_DEVICE;
            err_msg_o  <= user_dat_i[7:0];
          end else if (poll_ok) begin
            state  <= ST_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else if (last_poll) begin
            state      <= ST_ERROR;
            busy_o     <= 1'b0;
            err_o      <= 1'b1;
            err_code_o <= ERR_TIMEOUT;
          end else begin
            state <= ST_WAIT;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glitc_settings_loader.sv
// -----------------------------------------------------------------------------
// tb_glitc_settings_loader
// Scoreboard bench: each test queues the bus transactions it expects, and a
// monitor pops and compares every transaction the loader presents. Status
// outputs are checked directly by the stimulus thread.
// -----------------------------------------------------------------------------
module tb_glitc_settings_loader;

  localparam logic [15:0] PI = 16'd5;
  localparam logic [15:0] PL = 16'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [71:0] vped = '0;
  logic [35:0] atten = '0;
  logic        eeprom = 1'b0;
  logic        sel, wr, rd;
  logic [3:0]  addr;
  logic [31:0] dat_out;
  logic [31:0] dat_in;
  logic        busy, done, err;
  logic [1:0]  code;
  logic [7:0]  msg;

  glitc_settings_loader #(
    .POLL_INTERVAL (PI),
    .POLL_LIMIT    (PL)
  ) dut (
    .user_clk_i   (clk),
    .user_rst_n_i (rst_n),
    .start_i      (start),
    .vped_i       (vped),
    .atten_i      (atten),
    .eeprom_i     (eeprom),
    .user_sel_o   (sel),
    .user_wr_o    (wr),
    .user_rd_o    (rd),
    .user_addr_o  (addr),
    .user_dat_o   (dat_out),
    .user_dat_i   (dat_in),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .err_code_o   (code),
    .err_msg_o    (msg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic [3:0]  addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] stat_seq [0:7];
  int          rd_total = 0;
  int          rd_base  = 0;
  int          rd_idx;
  int          checks = 0;
  int          errors = 0;

  // Status word for the poll in progress (monitor bumps rd_total mid-cycle)
  always_comb begin
    rd_idx = rd_total - rd_base - 1;
    if (rd_idx < 0) rd_idx = 0;
    if (rd_idx > 7) rd_idx = 7;
  end
  assign dat_in = stat_seq[rd_idx];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor
  initial begin : monitor
    txn_t got;
    txn_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sel) begin
          got = {rd, addr, dat_out};
          check("wr_rd_exclusive", 64'(wr && rd), 64'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_txn", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            check("bus_txn", 64'(got), 64'(e));
          end
          if (rd) rd_total++;
        end else begin
          check("idle_bus", 64'({wr, rd, addr, dat_out}), 64'd0);
        end
      end
    end
  end

  int addr_tab [12] = '{0, 1, 2, 4, 5, 6, 8, 9, 10, 11, 12, 13};

  task automatic push_w(input int a, input logic [31:0] d);
    exp_q.push_back({1'b0, 4'(a), d});
  endtask

  task automatic push_r();
    exp_q.push_back({1'b1, 4'hE, 32'h0});
  endtask

  // Standard load: Vped 12'h800, atten 6'h15, eeprom set
  task automatic push_basic_load();
    for (int i = 0; i < 6; i++)  push_w(addr_tab[i], 32'h0000_8800);
    for (int i = 6; i < 12; i++) push_w(addr_tab[i], 32'h0000_0015);
    push_w(14, 32'h0);
  endtask

  task automatic set_basic_inputs();
    vped   = {6{12'h800}};
    atten  = {6{6'h15}};
    eeprom = 1'b1;
  endtask

  // Leaves the bench at the negedge of the first write cycle
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(output int cyc);
    cyc = 1;
    while (!done && !err && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin : stim
    int          cyc;
    logic [11:0] vv [6];
    logic [5:0]  av [6];
    vv = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF, 12'h001};
    av = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20};
    for (int i = 0; i < 8; i++) stat_seq[i] = 32'h0;

    // Reset state and no auto-start
    repeat (3) @(negedge clk);
    check("reset_status", 64'({busy, done, err, code, msg}), 64'd0);
    check("reset_bus", 64'({sel, wr, rd, addr, dat_out}), 64'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("no_autostart", 64'({busy, sel}), 64'd0);

    // Basic load, success on 4th poll
    set_basic_inputs();
    stat_seq[0] = 32'h8001_0000;
    stat_seq[1] = 32'h8001_0000;
    stat_seq[2] = 32'h8001_0000;
    stat_seq[3] = 32'h0001_0000;
    push_basic_load();
    repeat (4) push_r();
    rd_base = rd_total;
    pulse_start();
    check("busy_after_start", 64'(busy), 64'd1);
    wait_end(cyc);
    check("success_latency", 64'(cyc), 64'd38);
    check("success_status", 64'({busy, done, err, code}), 64'({1'b0, 1'b1, 1'b0, 2'd0}));
    check("success_queue", 64'(exp_q.size()), 64'd0);

    // Reload from DONE with new values; start during WAIT must be ignored
    vped   = {vv[5], vv[4], vv[3], vv[2], vv[1], vv[0]};
    atten  = {av[5], av[4], av[3], av[2], av[1], av[0]};
    eeprom = 1'b0;
    for (int i = 0; i < 6; i++) push_w(addr_tab[i], {20'h0, vv[i]});
    for (int i = 0; i < 6; i++) push_w(addr_tab[i+6], {26'h0, av[i]});
    push_w(14, 32'h0);
    push_r();
    for (int i = 0; i < 8; i++) stat_seq[i] = 32'h0001_0000;
    rd_base = rd_total;
    pulse_start();
    check("reload_clears_done", 64'({done, busy}), 64'({1'b0, 1'b1}));
    repeat (14) @(negedge clk);
    check("busy_in_wait", 64'(busy), 64'd1);
    vped = {6{12'hFFF}};
    pulse_start();
    wait_end(cyc);
    check("reload_latency", 64'(cyc), 64'd4);
    check("reload_status", 64'({busy, done, err, code}), 64'({1'b0, 1'b1, 1'b0, 2'd0}));
    check("reload_queue", 64'(exp_q.size()), 64'd0);

    // Timeout: status stuck at 0, POLL_LIMIT polls
    set_basic_inputs();
    for (int i = 0; i < 8; i++) stat_seq[i] = 32'h0;
    push_basic_load();
    repeat (4) push_r();
    rd_base = rd_total;
    pulse_start();
    wait_end(cyc);
    check("timeout_latency", 64'(cyc), 64'd38);
    check("timeout_status", 64'({busy, done, err, code, msg}),
          64'({1'b0, 1'b0, 1'b1, 2'd1, 8'h00}));
    check("timeout_queue", 64'(exp_q.size()), 64'd0);

    // Device error outranks completion flag in the same status word
    stat_seq[0] = 32'h0001_01A5;
    push_basic_load();
    push_r();
    rd_base = rd_total;
    pulse_start();
    check("error_cleared", 64'({err, code, msg, busy}), 64'({1'b0, 2'd0, 8'h00, 1'b1}));
    wait_end(cyc);
    check("device_latency", 64'(cyc), 64'd20);
    check("device_status", 64'({busy, done, err, code, msg}),
          64'({1'b0, 1'b0, 1'b1, 2'd2, 8'hA5}));
    check("device_queue", 64'(exp_q.size()), 64'd0);

    // Reset abort during the 5th write
    for (int i = 0; i < 5; i++) push_w(addr_tab[i], 32'h0000_8800);
    pulse_start();
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs", 64'({sel, wr, rd, addr, dat_out}), 64'd0);
    check("abort_status", 64'({busy, done, err, code, msg}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_stays_idle", 64'({busy, done, err}), 64'd0);
    check("abort_queue", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
